fft_frame_sequencer: RTL and testbench

Frames the 12 kHz signed microphone sample stream into fixed-length blocks and feeds them to the FFT core's AXI-Stream input. It generates `tvalid`/`tlast` and honours `tready` backpressure. It sits between the microphone decimator (`audio_sample_valid`/`mic_audio`) and the FFT `s_axis_data_*` port, all in the `clk_m` domain. Capture uses two ping-pong banks, so one frame is captured while the previous one streams. Overruns are detected and counted, never silently corrupting a frame.

---
 rtl/fft_frame_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - ping-pong framer from sample strobe to FFT AXI-Stream input
//
// Purpose: captures signed samples into two FRAME_LEN-deep banks and streams each
// completed bank, in capture order, as complex beats {16'h0, sample, 8'h00}.
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   enable_in                capture enable; falling edge discards the partial frame
//   sample_valid_in/sample_in  single-cycle sample strobe and signed sample
//   m_axis_tdata/tvalid/tlast/tready  stream to the FFT core
//   busy_out                 registered: a bank is full or a frame is in flight
//   overrun_out              sticky drop flag
//   drop_count_out           saturating dropped-sample count
//   frame_count_out          wrapping count of frames accepted by the FFT core
module fft_frame_sequencer #(
    parameter int FRAME_LEN    = 1024,
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic                    sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy_out,
    output logic                    overrun_out,
    output logic [15:0]             drop_count_out,
    output logic [15:0]             frame_count_out
);
    localparam int AW  = $clog2(FRAME_LEN);
    localparam int PAD = 16 - SAMPLE_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

    state_t            state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              enable_q;
    logic [31:0]       tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       drop_q, drop_d;
    logic [15:0]       frames_q, frames_d;
    logic              mem_we;

    // Both banks share one array; the bank bit is the address MSB.
    logic [SAMPLE_WIDTH-1:0] mem_q [2*FRAME_LEN];
    logic [SAMPLE_WIDTH-1:0] rd_data;

    assign rd_data = mem_q[{rd_bank_q, rd_addr_q}];

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[{wr_bank_q, wr_addr_q}] <= sample_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        frames_d  = frames_q;
        mem_we    = 1'b0;

        // Write side. Decisions use full_q, so a bank released this cycle still
        // counts as full and the colliding sample is dropped.
        if (enable_q && !enable_in) begin
            wr_addr_d = '0;
        end else if (enable_in && sample_valid_in) begin
            if (!full_q[wr_bank_q]) begin
                mem_we = 1'b1;
                if (wr_addr_q == LAST_ADDR) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_addr_d         = '0;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end else begin
                overrun_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end

        // Read side: the output register always holds the current beat and
        // rd_addr points at the next one, so a handshake reloads with no bubble.
        case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                if (full_q[rd_bank_q]) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                tdata_d   = {16'h0000, rd_data, {PAD{1'b0}}};
                tvalid_d  = 1'b1;
                tlast_d   = 1'b0;
                rd_addr_d = rd_addr_q + AW'(1);
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        tvalid_d          = 1'b0;
                        tlast_d           = 1'b0;
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        rd_addr_d         = '0;
                        frames_d          = frames_q + 16'd1;
                        state_d           = S_IDLE;
                    end else begin
                        tdata_d   = {16'h0000, rd_data, {PAD{1'b0}}};
                        tlast_d   = (rd_addr_q == LAST_ADDR);
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (|full_q) || (state_q != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            enable_q  <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
            enable_q  <= enable_in;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            frames_q  <= frames_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign busy_out        = busy_q;
    assign overrun_out     = overrun_q;
    assign drop_count_out  = drop_q;
    assign frame_count_out = frames_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;
    localparam int FL = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic        sample_valid_in;
    logic [7:0]  sample_in;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy_out;
    logic        overrun_out;
    logic [15:0] drop_count_out;
    logic [15:0] frame_count_out;

    always #5 clk_in = ~clk_in;

    fft_frame_sequencer #(.FRAME_LEN(FL), .SAMPLE_WIDTH(8)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out),
        .drop_count_out  (drop_count_out),
        .frame_count_out (frame_count_out)
    );

    typedef struct {
        logic [7:0]  sample;
        logic [31:0] tdata;
        logic        tlast;
    } vec_t;

    vec_t tbl [16];

    int tests = 0;
    int fails = 0;

    // Reference model: a frame is a list of accepted samples; a sample is
    // dropped when two completed frames are still waiting or streaming.
    int          occ;
    int          captured;
    int          exp_frames;
    int          exp_drops;
    bit          exp_ovr;
    int          beat_idx;
    logic [7:0]  partial [$];
    logic [7:0]  exp_q [$];
    logic [32:0] got_q [$];
    bit          pend;
    logic [31:0] pend_data;
    logic        pend_last;
    bit          bub_chk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, required none", nm);
    endtask

    task automatic model_reset();
        occ = 0; captured = 0; exp_frames = 0; exp_drops = 0; exp_ovr = 0;
        beat_idx = 0; partial.delete(); exp_q.delete(); got_q.delete();
        pend = 0; bub_chk = 0;
    endtask

    // One clock: drive inputs at the negedge, score what the coming posedge does.
    task automatic step(input bit en, input bit sv, input logic [7:0] s, input bit rdy);
        bit         hs;
        bit         last_beat;
        logic [7:0] e;
        enable_in       = en;
        sample_valid_in = sv;
        sample_in       = s;
        m_axis_tready   = rdy;
        if (pend) begin
            check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("hold_tdata", m_axis_tdata, pend_data);
            check("hold_tlast", 32'(m_axis_tlast), 32'(pend_last));
        end
        if (bub_chk && rdy) check("no_bubble", 32'(m_axis_tvalid), 32'd1);
        hs = m_axis_tvalid && rdy;
        last_beat = 0;
        if (hs) begin
            if (exp_q.size() == 0) begin
                fail_now("spurious_beat");
            end else begin
                e = exp_q.pop_front();
                last_beat = (beat_idx == FL - 1);
                check("beat_tdata", m_axis_tdata, {16'h0000, e, 8'h00});
                check("beat_tlast", 32'(m_axis_tlast), 32'(last_beat));
                beat_idx = last_beat ? 0 : beat_idx + 1;
            end
            got_q.push_back({m_axis_tlast, m_axis_tdata});
        end
        pend      = m_axis_tvalid && !rdy;
        pend_data = m_axis_tdata;
        pend_last = m_axis_tlast;
        bub_chk   = hs && !last_beat;
        if (!en) begin
            partial.delete();
        end else if (sv) begin
            if (occ == 2) begin
                if (exp_drops < 65535) exp_drops++;
                exp_ovr = 1;
            end else begin
                partial.push_back(s);
                if (partial.size() == FL) begin
                    foreach (partial[i]) exp_q.push_back(partial[i]);
                    partial.delete();
                    occ++;
                    captured++;
                end
            end
        end
        if (last_beat) begin
            occ--;
            exp_frames = (exp_frames + 1) % 65536;
        end
        @(negedge clk_in);
    endtask

    task automatic drain(input bit rnd);
        for (int k = 0; k < 400 && (exp_q.size() > 0 || occ > 0); k++) begin
            step(1'b1, 1'b0, 8'h00, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        if (exp_q.size() > 0 || occ > 0) fail_now("drain_timeout");
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("idle_busy", 32'(busy_out), 32'd0);
    endtask

    task automatic check_counters(input string nm);
        check({nm, "_frames"}, 32'(frame_count_out), 32'(exp_frames));
        check({nm, "_drops"}, 32'(drop_count_out), 32'(exp_drops));
        check({nm, "_overrun"}, 32'(overrun_out), 32'(exp_ovr));
    endtask

    task automatic do_reset();
        rst_in = 1'b1; enable_in = 1'b0; sample_valid_in = 1'b0;
        sample_in = 8'h00; m_axis_tready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    initial begin
        bit seen;
        int n0;

        tbl[0]  = '{8'h01, 32'h0000_0100, 1'b0};
        tbl[1]  = '{8'h02, 32'h0000_0200, 1'b0};
        tbl[2]  = '{8'h03, 32'h0000_0300, 1'b0};
        tbl[3]  = '{8'h04, 32'h0000_0400, 1'b0};
        tbl[4]  = '{8'h05, 32'h0000_0500, 1'b0};
        tbl[5]  = '{8'h06, 32'h0000_0600, 1'b0};
        tbl[6]  = '{8'h07, 32'h0000_0700, 1'b0};
        tbl[7]  = '{8'h08, 32'h0000_0800, 1'b1};
        tbl[8]  = '{8'h80, 32'h0000_8000, 1'b0};
        tbl[9]  = '{8'hFF, 32'h0000_FF00, 1'b0};
        tbl[10] = '{8'h7F, 32'h0000_7F00, 1'b0};
        tbl[11] = '{8'h00, 32'h0000_0000, 1'b0};
        tbl[12] = '{8'h40, 32'h0000_4000, 1'b0};
        tbl[13] = '{8'hC0, 32'h0000_C000, 1'b0};
        tbl[14] = '{8'h01, 32'h0000_0100, 1'b0};
        tbl[15] = '{8'hFE, 32'h0000_FE00, 1'b1};

        @(negedge clk_in);
        do_reset();
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_overrun", 32'(overrun_out), 32'd0);
        check("rst_drops", 32'(drop_count_out), 32'd0);
        check("rst_frames", 32'(frame_count_out), 32'd0);

        // Table frames: basic ramp then sign extremes, back to back, tready high.
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, tbl[i].sample, 1'b1);
            if (i >= 7 && !seen && m_axis_tvalid) begin
                seen = 1;
                check("start_latency_ok", 32'(i - 7 <= 2), 32'd1);
            end
        end
        if (!seen) fail_now("start_latency_timeout");
        drain(1'b0);
        check("tbl_beats", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            check($sformatf("tbl_tdata[%0d]", i), got_q[i][31:0], tbl[i].tdata);
            check($sformatf("tbl_tlast[%0d]", i), 32'(got_q[i][32]), 32'(tbl[i].tlast));
        end
        check("tbl_frames", 32'(frame_count_out), 32'd2);
        check_counters("tbl");

        // Overrun: both banks fill while tready is low, the third frame drops.
        got_q.delete();
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 8'(40 + i), 1'b0);
        check("ovr_drops", 32'(drop_count_out), 32'd8);
        check("ovr_flag", 32'(overrun_out), 32'd1);
        check("ovr_busy", 32'(busy_out), 32'd1);
        check_counters("ovr");
        drain(1'b0);
        check("ovr_beats", 32'(got_q.size()), 32'd16);
        check_counters("ovr_done");

        // Disable mid-frame discards the partial frame.
        got_q.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(90 + i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(10 + i), 1'b1);
        drain(1'b0);
        check("dis_beats", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check($sformatf("dis_tdata[%0d]", i), got_q[i][31:0], {16'h0, 8'(10 + i), 8'h00});
        check_counters("dis");

        // Random samples and random backpressure over four frames.
        n0 = exp_frames;
        for (int k = 0; k < 3000 && captured < 9; k++)
            step(1'b1, ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
        if (captured < 9) fail_now("rand_capture_timeout");
        drain(1'b1);
        check("rand_frames", 32'(exp_frames - n0), 32'd4);
        check_counters("rand");

        // Reset after three accepted beats.
        got_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(i + 60), 1'b0);
        for (int k = 0; k < 20 && got_q.size() < 3; k++) step(1'b1, 1'b0, 8'h00, 1'b1);
        check("mid_beats", 32'(got_q.size()), 32'd3);
        rst_in = 1'b1; m_axis_tready = 1'b1; sample_valid_in = 1'b0;
        @(negedge clk_in);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_frames", 32'(frame_count_out), 32'd0);
        check("mid_rst_drops", 32'(drop_count_out), 32'd0);
        check("mid_rst_overrun", 32'(overrun_out), 32'd0);
        rst_in = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(i + 100), 1'b1);
        drain(1'b0);
        check("post_rst_beats", 32'(got_q.size()), 32'd8);
        check("post_rst_frames", 32'(frame_count_out), 32'd1);
        check_counters("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
